// File: rtl/pipe_pkg.sv
// Shared pipeline widths, per-stage payload layouts and their flush/bubble defaults.
package pipe_pkg;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned INSTR_W = 32;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } if_id_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     rs1_val;
      logic [31:0]     rs2_val;
      logic [31:0]     imm;
      logic [4:0]      rd;
      logic [7:0]      ctrl;
   } id_ex_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     alu_res;
      logic [31:0]     store_val;
      logic [4:0]      rd;
      logic [7:0]      ctrl;
   } ex_mem_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     wb_val;
      logic [4:0]      rd;
      logic [7:0]      ctrl;
   } mem_wb_t;

   localparam int unsigned IF_ID_W  = $bits(if_id_t);
   localparam int unsigned ID_EX_W  = $bits(id_ex_t);
   localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
   localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

   // IF/ID keeps pc and turns the instruction into the all-zero bubble.
   localparam logic [IF_ID_W-1:0] IF_ID_FLUSH_MASK = {{PC_W{1'b0}}, {INSTR_W{1'b1}}};
   localparam logic [IF_ID_W-1:0] IF_ID_BUBBLE     = '0;

   // Later stages only need their control bits killed to become harmless.
   localparam logic [ID_EX_W-1:0]  ID_EX_FLUSH_MASK  = ID_EX_W'(8'hFF);
   localparam logic [ID_EX_W-1:0]  ID_EX_BUBBLE      = '0;
   localparam logic [EX_MEM_W-1:0] EX_MEM_FLUSH_MASK = EX_MEM_W'(8'hFF);
   localparam logic [EX_MEM_W-1:0] EX_MEM_BUBBLE     = '0;
   localparam logic [MEM_WB_W-1:0] MEM_WB_FLUSH_MASK = MEM_WB_W'(8'hFF);
   localparam logic [MEM_WB_W-1:0] MEM_WB_BUBBLE     = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle of one pipeline stage register; slave is the stage, master drives it.
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W = 64
) ();

   logic              valid_i;
   logic [DATA_W-1:0] data_i;
   logic              ready_o;
   logic              flush_i;
   logic              valid_o;
   logic [DATA_W-1:0] data_o;
   logic              ready_i;

   modport slave (
      input  valid_i, data_i, flush_i, ready_i,
      output ready_o, valid_o, data_o
   );

   modport master (
      output valid_i, data_i, flush_i, ready_i,
      input  ready_o, valid_o, data_o
   );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low reset.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush-to-bubble and stall counter.
// Define PIPE_REG_SKID_EN to add a second (skid) entry and register ready_o.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W     = IF_ID_W,
   parameter logic [DATA_W-1:0] FLUSH_MASK = IF_ID_FLUSH_MASK,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = IF_ID_BUBBLE,
   parameter int unsigned       CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   pipe_stage_reg_if.slave  bus_io,
   output logic [CNT_W-1:0] stall_cnt_o
);

   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic              ready;
   logic              accept;
   logic              consume;
   logic [DATA_W-1:0] flush_data;

   assign accept     = bus_io.valid_i & ready;
   assign consume    = m_valid_q & bus_io.ready_i;
   assign flush_data = (bus_io.data_i & ~FLUSH_MASK) | (BUBBLE_VAL & FLUSH_MASK);

`ifdef PIPE_REG_SKID_EN
   logic              s_valid_q, s_valid_d;
   logic [DATA_W-1:0] s_data_q, s_data_d;

   // S is only ever occupied behind a full M, so its emptiness alone says we can take more.
   assign ready = ~s_valid_q;

   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      if (bus_io.flush_i) begin
         m_valid_d = 1'b0;
         m_data_d  = flush_data;
         s_valid_d = 1'b0;
      end else if (!m_valid_q || consume) begin
         if (s_valid_q) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data_q;
            s_valid_d = accept;
            if (accept) begin
               s_data_d = bus_io.data_i;
            end
         end else begin
            m_valid_d = accept;
            if (accept) begin
               m_data_d = bus_io.data_i;
            end
         end
      end else if (accept) begin
         s_valid_d = 1'b1;
         s_data_d  = bus_io.data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         s_valid_q <= 1'b0;
         s_data_q  <= BUBBLE_VAL;
      end else begin
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
      end
   end
`else
   assign ready = ~m_valid_q | bus_io.ready_i;

   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      if (bus_io.flush_i) begin
         m_valid_d = 1'b0;
         m_data_d  = flush_data;
      end else if (!m_valid_q || consume) begin
         m_valid_d = accept;
         if (accept) begin
            m_data_d = bus_io.data_i;
         end
      end
   end
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         m_valid_q <= 1'b0;
         m_data_q  <= BUBBLE_VAL;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
      end
   end

   assign bus_io.ready_o = ready;
   assign bus_io.valid_o = m_valid_q;
   assign bus_io.data_o  = m_data_q;

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (m_valid_q & ~bus_io.ready_i),
      .cnt_o (stall_cnt_o)
   );

endmodule
